gate_eval_arbiter: RTL and testbench

GATE_EVAL_ARBITER -- requirements
Module: gate_eval_arbiter

---
 rtl/gate_eval_arbiter.sv | 137 +++++++++++++
 tb/tb_gate_eval_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter for three requesters feeding a shared 3-input AND/OR gate evaluator.
// One transaction at a time: grant and capture in IDLE, hold for EVAL_LAT cycles, publish in RESP.
module gate_eval_arbiter #(
  parameter int EVAL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] opnd_0,
  input  logic [2:0] opnd_1,
  input  logic [2:0] opnd_2,
  output logic [2:0] gnt,
  output logic       rsp_valid,
  output logic [1:0] rsp_id,
  output logic       out_1,
  output logic       out_2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(EVAL_LAT - 1);

  generate
    if (EVAL_LAT < 1 || EVAL_LAT > 4) begin : g_bad_eval_lat
      $error("gate_eval_arbiter: EVAL_LAT must be in 1..4");
    end
  endgenerate

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] cnt_reg;
  logic [1:0] ptr_reg;
  logic [1:0] win_id_reg;
  logic [2:0] opnd_reg;

  logic [2:0] opnd_arr [3];
  logic [1:0] order_idx [3];
  logic       win_valid;
  logic [1:0] win_id;
  logic [2:0] win_onehot;
  logic       capture_en;
  logic       rsp_load;
  logic       ptr_load;

  assign opnd_arr[0] = opnd_0;
  assign opnd_arr[1] = opnd_1;
  assign opnd_arr[2] = opnd_2;

  // Search order starts at the pointer and wraps modulo 3.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_order
      logic [2:0] sum;
      assign sum           = {1'b0, ptr_reg} + 3'(gi);
      assign order_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    end
  endgenerate

  // Walk the order backwards so the earliest requester in the order wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req[order_idx[k]]) begin
        win_valid = 1'b1;
        win_id    = order_idx[k];
      end
    end
  end

  assign win_onehot = 3'b001 << win_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_valid) state_next = EVAL;
      EVAL:    if (cnt_reg == LAST_CNT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    rsp_load   = 1'b0;
    ptr_load   = 1'b0;
    case (state_reg)
      IDLE:    capture_en = win_valid;
      EVAL:    rsp_load   = (cnt_reg == LAST_CNT);
      RESP:    ptr_load   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 2'd0;
      ptr_reg    <= 2'd0;
      win_id_reg <= 2'd0;
      opnd_reg   <= 3'd0;
      gnt        <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      out_1      <= 1'b0;
      out_2      <= 1'b0;
    end else begin
      gnt       <= capture_en ? win_onehot : 3'd0;
      rsp_valid <= rsp_load;
      cnt_reg   <= (state_reg == EVAL && !rsp_load) ? cnt_reg + 2'd1 : 2'd0;
      if (capture_en) begin
        opnd_reg   <= opnd_arr[win_id];
        win_id_reg <= win_id;
      end
      if (rsp_load) begin
        out_1  <= &opnd_reg;
        out_2  <= |opnd_reg;
        rsp_id <= win_id_reg;
      end
      if (ptr_load) begin
        ptr_reg <= (win_id_reg == 2'd2) ? 2'd0 : win_id_reg + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Randomized scoreboard bench for gate_eval_arbiter: stimulus pushes expected grants/results,
// a negedge monitor pops and compares them as the DUT presents gnt and rsp_valid.
module tb_gate_eval_arbiter;
  localparam int EVAL_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'd0;
  logic [2:0] opnd_0 = 3'd0;
  logic [2:0] opnd_1 = 3'd0;
  logic [2:0] opnd_2 = 3'd0;
  logic [2:0] gnt;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       out_1;
  logic       out_2;

  gate_eval_arbiter #(.EVAL_LAT(EVAL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .opnd_0(opnd_0), .opnd_1(opnd_1), .opnd_2(opnd_2),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .out_1(out_1), .out_2(out_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] id;
    logic       o1;
    logic       o2;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   m_ptr = 0;
  int   last_gnt_cyc = 0;
  bit   front_granted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference: first requester at or after the pointer wins; result is all-ones / nonzero test.
  task automatic model_push(input logic [2:0] mask, input logic [2:0] op0, input logic [2:0] op1,
                            input logic [2:0] op2);
    logic [2:0] ops [3];
    int   w;
    exp_t e;
    ops = '{op0, op1, op2};
    w = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (w < 0 && mask[i]) w = i;
    end
    if (w >= 0) begin
      e.gnt = 3'(1 << w);
      e.id  = 2'(w);
      e.o1  = (ops[w] == 3'b111);
      e.o2  = (ops[w] != 3'b000);
      exp_q.push_back(e);
      m_ptr = (w + 1) % 3;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (gnt != 3'd0) begin
        gnt_cyc_q.push_back(cycle);
        if (exp_q.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'd0);
        else if (front_granted) chk("extra_gnt", 32'(gnt), 32'd0);
        else begin
          chk("gnt", 32'(gnt), 32'(exp_q[0].gnt));
          front_granted = 1'b1;
          last_gnt_cyc  = cycle;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0 || !front_granted) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          front_granted = 1'b0;
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("out_1", 32'(out_1), 32'(e.o1));
          chk("out_2", 32'(out_2), 32'(e.o2));
          chk("rsp_latency", 32'(cycle - last_gnt_cyc), 32'(EVAL_LAT));
        end
      end
    end
  end

  // smode: 0 keep operands, 1 randomize, 2 zero them once granted.
  task automatic do_txn(input logic [2:0] mask, input logic [2:0] o0, input logic [2:0] o1,
                        input logic [2:0] o2, input int smode, output logic [2:0] seen_gnt);
    int n;
    @(negedge clk);
    req = mask;
    opnd_0 = o0;
    opnd_1 = o1;
    opnd_2 = o2;
    model_push(mask, o0, o1, o2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 3'd0 && n < 8);
    chk("gnt_latency", 32'(n), 32'd1);
    seen_gnt = gnt;
    req = 3'd0;
    if (smode == 1) begin
      opnd_0 = 3'($urandom);
      opnd_1 = 3'($urandom);
      opnd_2 = 3'($urandom);
    end else if (smode == 2) begin
      opnd_0 = 3'd0;
      opnd_1 = 3'd0;
      opnd_2 = 3'd0;
    end
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    int base, n_rsp, n;
    logic [2:0] mask;
    #12;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_out_1", 32'(out_1), 32'd0);
    chk("reset_out_2", 32'(out_2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all three held, grants 0,1,2,0 spaced EVAL_LAT+2 apart.
    @(negedge clk);
    req = 3'b111;
    opnd_0 = 3'b111;
    opnd_1 = 3'b101;
    opnd_2 = 3'b000;
    base = gnt_cyc_q.size();
    repeat (4) model_push(3'b111, 3'b111, 3'b101, 3'b000);
    n_rsp = 0;
    n = 0;
    while (n_rsp < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) n_rsp++;
    end
    req = 3'd0;
    chk("fair_rsp_count", 32'(n_rsp), 32'd4);
    repeat (3) @(negedge clk);
    chk("fair_gnt_count", 32'(gnt_cyc_q.size() - base), 32'd4);
    if (gnt_cyc_q.size() - base == 4) begin
      for (int k = 1; k < 4; k++)
        chk("fair_gnt_period", 32'(gnt_cyc_q[base+k] - gnt_cyc_q[base+k-1]), 32'(EVAL_LAT + 2));
    end

    do_txn(3'b010, 3'b000, 3'b111, 3'b000, 0, g);
    chk("single_gnt", 32'(g), 32'b010);
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd1);
    chk("single_out_1", 32'(out_1), 32'd1);
    chk("single_out_2", 32'(out_2), 32'd1);

    do_txn(3'b001, 3'b000, 3'b000, 3'b000, 0, g);
    chk("tv000_out_1", 32'(out_1), 32'd0);
    chk("tv000_out_2", 32'(out_2), 32'd0);
    do_txn(3'b001, 3'b101, 3'b000, 3'b000, 0, g);
    chk("tv101_out_1", 32'(out_1), 32'd0);
    chk("tv101_out_2", 32'(out_2), 32'd1);
    do_txn(3'b001, 3'b111, 3'b000, 3'b000, 0, g);
    chk("tv111_out_1", 32'(out_1), 32'd1);
    chk("tv111_out_2", 32'(out_2), 32'd1);

    do_txn(3'b100, 3'b000, 3'b000, 3'b011, 0, g);
    chk("wrap_pre_gnt", 32'(g), 32'b100);
    do_txn(3'b101, 3'b001, 3'b000, 3'b110, 0, g);
    chk("wrap_gnt", 32'(g), 32'b001);

    do_txn(3'b001, 3'b111, 3'b000, 3'b000, 2, g);
    chk("stable_out_1", 32'(out_1), 32'd1);
    chk("stable_out_2", 32'(out_2), 32'd1);
    repeat (2) @(negedge clk);
    chk("hold_out_1", 32'(out_1), 32'd1);
    chk("hold_rsp_id", 32'(rsp_id), 32'd0);

    // Reset in the second cycle of a transaction, with nonzero results on the outputs.
    do_txn(3'b010, 3'b000, 3'b111, 3'b000, 0, g);
    @(negedge clk);
    req = 3'b001;
    opnd_0 = 3'b111;
    model_push(3'b001, 3'b111, 3'b111, 3'b000);
    @(negedge clk);
    req = 3'd0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    front_granted = 1'b0;
    m_ptr = 0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_out_1", 32'(out_1), 32'd0);
    chk("rst_mid_out_2", 32'(out_2), 32'd0);
    chk("rst_mid_rsp_id", 32'(rsp_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("rst_no_rsp", 32'(n_rsp), 32'd0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mask = 3'($urandom_range(1, 7));
      do_txn(mask, 3'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 1)), g);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
